// File: rtl/seq_datapath.sv
// Multi-cycle register-file datapath: fetch (T0/T1), decode (T2/T3), execute (T4), write-back (T5).
// Optional multiplier and HI/LO registers are enabled by defining SEQ_DATAPATH_MUL_EN.
module seq_datapath #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              run,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              halted,
   output logic              err,
   output logic [ADDR_W-1:0] pc_out,
   input  logic [3:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);
   localparam int unsigned C_W = DATA_W - 17;
`ifdef SEQ_DATAPATH_MUL_EN
   localparam int unsigned Z_W = 2 * DATA_W;
   localparam logic [4:0]  OP_MUL = 5'b01111;
`else
   localparam int unsigned Z_W = DATA_W;
`endif
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_NOT  = 5'b00100;
   localparam logic [4:0] OP_LDI  = 5'b00101;
   localparam logic [4:0] OP_HALT = 5'b11111;

   typedef enum logic [2:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
   } state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_reg [16];
   logic [ADDR_W-1:0] r_pc, r_mar;
   logic [DATA_W-1:0] r_ir, r_mdr, r_y;
   logic [Z_W-1:0]    r_z, w_z;
   logic              r_err, w_set_err, w_legal;
   logic [4:0]        w_op;
   logic [3:0]        w_ra, w_rb, w_rc;
   logic [DATA_W-1:0] w_c, w_b, w_res;

   // Instruction field decode from IR
   assign w_op = r_ir[DATA_W-1  -: 5];
   assign w_ra = r_ir[DATA_W-6  -: 4];
   assign w_rb = r_ir[DATA_W-10 -: 4];
   assign w_rc = r_ir[DATA_W-14 -: 4];
   assign w_c  = {{(DATA_W-C_W){r_ir[C_W-1]}}, r_ir[C_W-1:0]};
   assign w_b  = r_reg[w_rb];

   always_comb begin
      w_legal = 1'b0;
      case (w_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_LDI: w_legal = 1'b1;
`ifdef SEQ_DATAPATH_MUL_EN
         OP_MUL:  w_legal = 1'b1;
`endif
         default: w_legal = 1'b0;
      endcase
   end

   // Execute-stage result; arithmetic wraps at DATA_W
   always_comb begin
      w_res = '0;
      case (w_op)
         OP_ADD:  w_res = r_y + w_b;
         OP_SUB:  w_res = r_y - w_b;
         OP_AND:  w_res = r_y & w_b;
         OP_OR:   w_res = r_y | w_b;
         OP_NOT:  w_res = ~r_y;
         OP_LDI:  w_res = w_c;
         default: w_res = '0;
      endcase
`ifdef SEQ_DATAPATH_MUL_EN
      if (w_op == OP_MUL) w_z = Z_W'(r_y) * Z_W'(w_b);
      else                w_z = {{DATA_W{1'b0}}, w_res};
`else
      w_z = w_res;
`endif
   end

   always_ff @(posedge clock) begin
      if (!clear) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_set_err = 1'b0;
      case (r_state)
         S_IDLE: if (run) w_next = S_T0;
         S_T0:   w_next = S_T1;
         S_T1:   if (mem_ack) w_next = S_T2;
         S_T2:   w_next = S_T3;
         S_T3: begin
            if (w_op == OP_HALT) begin
               w_next = S_HALT;
            end else if (!w_legal) begin
               w_next    = S_HALT;
               w_set_err = 1'b1;
            end else begin
               w_next = S_T4;
            end
         end
         S_T4:   w_next = S_T5;
         S_T5:   w_next = run ? S_T0 : S_IDLE;
         S_HALT: w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

`ifdef SEQ_DATAPATH_MUL_EN
   logic [DATA_W-1:0] r_hi, r_lo;
   assign hi_out = r_hi;
   assign lo_out = r_lo;
`else
   assign hi_out = '0;
   assign lo_out = '0;
`endif

   // Datapath register transfers per state
   always_ff @(posedge clock) begin
      if (!clear) begin
         r_reg <= '{default: '0};
         r_pc  <= '0;
         r_mar <= '0;
         r_ir  <= '0;
         r_mdr <= '0;
         r_y   <= '0;
         r_z   <= '0;
         r_err <= 1'b0;
`ifdef SEQ_DATAPATH_MUL_EN
         r_hi  <= '0;
         r_lo  <= '0;
`endif
      end else begin
         case (r_state)
            S_T0: begin
               r_mar <= r_pc;
               r_pc  <= r_pc + ADDR_W'(1);
            end
            S_T1: if (mem_ack) r_mdr <= mem_rdata;
            S_T2: r_ir <= r_mdr;
            S_T3: begin
               if (w_set_err)           r_err <= 1'b1;
               else if (w_next == S_T4) r_y   <= r_reg[w_ra];
            end
            S_T4: r_z <= w_z;
            S_T5: begin
`ifdef SEQ_DATAPATH_MUL_EN
               if (w_op == OP_MUL) begin
                  r_hi <= r_z[Z_W-1:DATA_W];
                  r_lo <= r_z[DATA_W-1:0];
               end else begin
                  r_reg[w_rc] <= r_z[DATA_W-1:0];
               end
`else
               r_reg[w_rc] <= r_z;
`endif
            end
            default: ;
         endcase
      end
   end

   assign mem_req  = (r_state == S_T1);
   assign halted   = (r_state == S_HALT);
   assign mem_addr = r_mar;
   assign pc_out   = r_pc;
   assign err      = r_err;
   assign dbg_data = r_reg[dbg_sel];

endmodule
